// File: rtl/ddp_pkg.sv
// Shared definitions for the data-driven pipeline copy stage.
//   PKT_IN_W / PKT_OUT_W : packet widths on the upstream and downstream side
//   Field constants      : bit positions within the 40-bit input packet
//   copy_seq_state_t     : copy_sequencer FSM states
package ddp_pkg;

    localparam int unsigned PKT_IN_W    = 40;
    localparam int unsigned PKT_OUT_W   = 38;

    localparam int unsigned DEST_MSB    = 28;
    localparam int unsigned DEST_LSB    = 22;
    localparam int unsigned LR_ORIG_BIT = 21;
    localparam int unsigned LR_COPY_BIT = 20;
    localparam int unsigned CPY_BIT     = 18;

    localparam int unsigned DEST_W      = DEST_MSB - DEST_LSB + 1;

    typedef enum logic [1:0] {
        EMPTY,
        ORIG,
        COPY
    } copy_seq_state_t;

endpackage

// File: rtl/copy_pkt_fmt.sv
// Combinational output formatter for the copy stage.
// Ports:
//   dl_i      : held 40-bit input packet
//   is_copy_i : 0 = original beat, 1 = copy beat (dest+1, copy LR bit)
//   pkt_o     : 38-bit output packet {DL[39:29], dest, lr, DL[19], DL[17:0]}
module copy_pkt_fmt
    import ddp_pkg::*;
(
    input  logic [PKT_IN_W-1:0]  dl_i,
    input  logic                 is_copy_i,
    output logic [PKT_OUT_W-1:0] pkt_o
);

    logic [DEST_W-1:0] dest_orig;
    logic [DEST_W-1:0] dest_inc;
    logic [DEST_W-1:0] dest_sel;
    logic              lr_sel;

    assign dest_orig = dl_i[DEST_MSB:DEST_LSB];
    // Wraps modulo 128: 7'h7F -> 7'h00.
    assign dest_inc  = dest_orig + DEST_W'(1);

    always_comb begin
        dest_sel = dest_orig;
        lr_sel   = dl_i[LR_ORIG_BIT];
        if (is_copy_i) begin
            dest_sel = dest_inc;
            lr_sel   = dl_i[LR_COPY_BIT];
        end
    end

    // The CPY flag itself is dropped from the output.
    assign pkt_o = {dl_i[PKT_IN_W-1:DEST_MSB+1], dest_sel, lr_sel,
                    dl_i[CPY_BIT+1], dl_i[CPY_BIT-1:0]};

endmodule

// File: rtl/copy_sequencer.sv
// Copy-stage sequencer: accepts one 40-bit packet per handshake, emits the
// original 38-bit packet and, when CPY is set, a second copy with dest+1.
// Ports:
//   CLK        : system clock
//   MR         : synchronous active-high master reset
//   Send_in    : upstream offers PACKET_IN
//   Ack_out    : block can accept (transfer in = Send_in && Ack_out)
//   PACKET_IN  : 40-bit input packet
//   Send_out   : PACKET_OUT valid
//   Ack_in     : downstream accepts (transfer out = Send_out && Ack_in)
//   PACKET_OUT : 38-bit formatted output packet
// Build option: COPY_SEQ_PIPE_EN lets a new packet load on the same edge as
// the final beat leaves, removing the bubble cycle between packets.
module copy_sequencer
    import ddp_pkg::*;
(
    input  logic                 CLK,
    input  logic                 MR,
    input  logic                 Send_in,
    output logic                 Ack_out,
    input  logic [PKT_IN_W-1:0]  PACKET_IN,
    output logic                 Send_out,
    input  logic                 Ack_in,
    output logic [PKT_OUT_W-1:0] PACKET_OUT
);

    copy_seq_state_t     state_q, state_d;
    logic [PKT_IN_W-1:0] dl_q, dl_d;
    logic                send_q, send_d;
    logic                xfer_in;
    logic                xfer_out;

    assign xfer_in  = Send_in && Ack_out;
    assign xfer_out = send_q && Ack_in;

`ifdef COPY_SEQ_PIPE_EN
    logic final_beat;

    // Final beat: the beat after which the packet is fully emitted.
    assign final_beat = ((state_q == ORIG) && !dl_q[CPY_BIT]) || (state_q == COPY);
    assign Ack_out    = !MR && ((state_q == EMPTY) || (final_beat && Ack_in));
`else
    assign Ack_out    = !MR && (state_q == EMPTY);
`endif

    always_comb begin
        state_d = state_q;
        dl_d    = dl_q;

        unique case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    state_d = ORIG;
                end
            end
            ORIG: begin
                if (xfer_out) begin
                    state_d = dl_q[CPY_BIT] ? COPY : EMPTY;
                end
            end
            COPY: begin
                if (xfer_out) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        // A transfer-in outside EMPTY only happens on a final beat (pipelined
        // build), so loading here overrides the EMPTY transition seamlessly.
        if (xfer_in) begin
            dl_d    = PACKET_IN;
            state_d = ORIG;
        end

        send_d = (state_d != EMPTY);
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            state_q <= EMPTY;
            dl_q    <= '0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= dl_d;
            send_q  <= send_d;
        end
    end

    assign Send_out = send_q;

    copy_pkt_fmt u_fmt (
        .dl_i      (dl_q),
        .is_copy_i (state_q == COPY),
        .pkt_o     (PACKET_OUT)
    );

endmodule

// File: tb/tb_copy_sequencer.sv
// Self-checking bench for copy_sequencer using an expected-packet scoreboard.
module tb_copy_sequencer;

    logic        CLK;
    logic        MR;
    logic        Send_in;
    logic        Ack_out;
    logic [39:0] PACKET_IN;
    logic        Send_out;
    logic        Ack_in;
    logic [37:0] PACKET_OUT;

`ifdef COPY_SEQ_PIPE_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    copy_sequencer dut (
        .CLK        (CLK),
        .MR         (MR),
        .Send_in    (Send_in),
        .Ack_out    (Ack_out),
        .PACKET_IN  (PACKET_IN),
        .Send_out   (Send_out),
        .Ack_in     (Ack_in),
        .PACKET_OUT (PACKET_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [37:0] exp_q[$];
    bit          stream_on = 0;
    bit          have_last = 0;
    int          last_cyc  = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [37:0] fmt_exp(input logic [39:0] p, input logic cp);
        logic [6:0] d;
        d = p[28:22];
        if (cp) d = d + 7'd1;
        return {p[39:29], d, (cp ? p[20] : p[21]), p[19], p[17:0]};
    endfunction

    function automatic logic [39:0] make_pkt(input logic [6:0] dest, input logic lr_o,
                                             input logic lr_c, input logic cpy);
        logic [39:0] p;
        p        = {$urandom, $urandom};
        p[28:22] = dest;
        p[21]    = lr_o;
        p[20]    = lr_c;
        p[18]    = cpy;
        return p;
    endfunction

    // Monitor: inputs are driven 1 time unit after posedge, so at negedge the
    // handshake values are exactly those the next edge will see.
    always @(negedge CLK) begin
        if (MR) begin
            exp_q.delete();
        end else begin
            if (Send_out && Ack_in) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_no_expect", Send_out, 1'b0);
                end else begin
                    check_eq("pkt_out", PACKET_OUT, exp_q.pop_front());
                end
                if (stream_on) begin
                    if (have_last) check_eq("stream_gap", cyc - last_cyc, GAP);
                    last_cyc  = cyc;
                    have_last = 1;
                end
            end
            if (Send_in && Ack_out) begin
                exp_q.push_back(fmt_exp(PACKET_IN, 1'b0));
                if (PACKET_IN[18]) exp_q.push_back(fmt_exp(PACKET_IN, 1'b1));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push_pkt(input logic [39:0] p);
        bit acc;
        Send_in   = 1'b1;
        PACKET_IN = p;
        acc       = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (Ack_out) begin
                acc = 1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        check_eq("accept_timeout", acc, 1'b1);
        check_eq("latency_send", Send_out, 1'b1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !Send_out) begin
                done = 1;
                break;
            end
        end
        check_eq("drain_timeout", done, 1'b1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [39:0] pk;

    initial begin
        MR        = 1'b1;
        Send_in   = 1'b0;
        Ack_in    = 1'b0;
        PACKET_IN = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_send_out", Send_out, 1'b0);
        check_eq("rst_ack_out", Ack_out, 1'b0);
        check_eq("rst_pkt_out", PACKET_OUT, 38'b0);
        @(posedge CLK);
        #1;
        MR = 1'b0;
        #1;
        check_eq("ack_after_rst", Ack_out, 1'b1);
        @(posedge CLK);
        #1;

        // Non-copy packet
        Ack_in = 1'b1;
        push_pkt(make_pkt(7'h05, 1'b1, 1'b0, 1'b0));
        Send_in = 1'b0;
        drain();

        // Copy packet
        push_pkt(make_pkt(7'h05, 1'b0, 1'b1, 1'b1));
        Send_in = 1'b0;
        drain();

        // Destination wrap on copy
        push_pkt(make_pkt(7'h7F, 1'b1, 1'b0, 1'b1));
        Send_in = 1'b0;
        drain();

        // Backpressure in ORIG, with a competing offer upstream
        Ack_in = 1'b0;
        pk = make_pkt(7'h33, 1'b0, 1'b1, 1'b1);
        push_pkt(pk);
        PACKET_IN = make_pkt(7'h11, 1'b1, 1'b1, 1'b0);
        Send_in   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_eq("bp_send_out", Send_out, 1'b1);
            check_eq("bp_pkt_held", PACKET_OUT, fmt_exp(pk, 1'b0));
            check_eq("bp_ack_out", Ack_out, 1'b0);
        end
        @(posedge CLK);
        #1;
        Send_in = 1'b0;
        Ack_in  = 1'b1;
        drain();

        // Reset while the copy beat is pending
        pk = make_pkt(7'h20, 1'b1, 1'b0, 1'b1);
        push_pkt(pk);
        Send_in = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("copy_pending_send", Send_out, 1'b1);
        check_eq("copy_pending_pkt", PACKET_OUT, fmt_exp(pk, 1'b1));
        MR     = 1'b1;
        Ack_in = 1'b0;
        @(posedge CLK);
        #1;
        check_eq("mr_send_out", Send_out, 1'b0);
        check_eq("mr_pkt_out", PACKET_OUT, 38'b0);
        check_eq("mr_ack_out", Ack_out, 1'b0);
        MR = 1'b0;
        #1;
        check_eq("mr_ack_after", Ack_out, 1'b1);
        Ack_in = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check_eq("mr_no_copy", Send_out, 1'b0);
        check_eq("mr_queue_empty", exp_q.size(), 0);

        // Back-to-back streaming of non-copy packets
        stream_on = 1;
        have_last = 0;
        for (int i = 0; i < 4; i++) begin
            push_pkt(make_pkt(7'(8'h40 + i), i[0], ~i[0], 1'b0));
        end
        Send_in = 1'b0;
        drain();
        stream_on = 0;
        check_eq("stream_seen", have_last, 1'b1);

        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/copy_sequencer.md
# copy_sequencer

Synchronous controller that sequences the copy stage of the data-driven pipeline. It accepts one 40-bit packet per handshake, holds it, and emits the original 38-bit output packet. When the packet's CPY flag is set, it then emits a second copy packet with destination+1. It sits between the matching/fetch side (upstream) and the node-routing stage (downstream), and replaces the self-timed CX2 sequencing with a single-clock FSM.

## Interface
- Parameters: none. Field positions and widths come from the shared package.
- CLK  in  1  system clock; all state changes on rising edge.
- MR  in  1  master reset; synchronous, active-high.
- Send_in  in  1  upstream offers PACKET_IN.
- Ack_out  out  1  block can accept. Transfer in = Send_in && Ack_out at a CLK edge.
- PACKET_IN  in  40  input packet: [39:29] passthrough, [28:22] dest, [21] LR for original, [20] LR for copy, [19] passthrough, [18] CPY, [17:0] passthrough.
- Send_out  out  1  PACKET_OUT valid.
- Ack_in  in  1  downstream accepts. Transfer out = Send_out && Ack_in at a CLK edge.
- PACKET_OUT  out  38  {DL[39:29], dest_sel, lr_sel, DL[19], DL[17:0]}.

## Operation
- Holding register DL[39:0] is loaded only on a transfer-in.
- Output formatting (combinational from DL and state):
  - Original: dest_sel = DL[28:22]; lr_sel = DL[21].
  - Copy: dest_sel = DL[28:22] + 1, modulo 128 (7'h7F → 7'h00); lr_sel = DL[20].
  - DL[18] is dropped from the output.
- FSM states: EMPTY, ORIG, COPY.
  - EMPTY: Send_out=0, Ack_out=1. Transfer-in → load DL, go to ORIG.
  - ORIG: Send_out=1, original format, Ack_out=0 (see Configuration). Transfer-out: DL[18]=1 → COPY; DL[18]=0 → EMPTY.
  - COPY: Send_out=1, copy format, Ack_out=0 (see Configuration). Transfer-out → EMPTY.
- Send_out, once asserted, stays high with PACKET_OUT stable until Ack_in. No retraction and no reordering.
- Ack_in while Send_out=0 is ignored.
- Send_in while Ack_out=0 is ignored; upstream must hold the packet.
- MR high: state → EMPTY, DL → 40'b0, Ack_out=0 during MR. Any held or half-emitted packet (including a pending copy) is discarded.

## Timing
- Reset values while MR is high:
  - Send_out=0, Ack_out=0, PACKET_OUT=38'b0.
  - From the first cycle after MR deasserts: Ack_out=1.
- Latency: transfer-in at edge N → Send_out=1 in cycle N+1 (earliest original transfer-out at edge N+1). Copy earliest at edge N+2.
- Throughput without PIPE_EN:
  - Non-copy packet: 2 cycles per packet.
  - Copy packet: 3 cycles per packet.
- Throughput with PIPE_EN:
  - Non-copy packet: 1 cycle per packet.
  - Copy packet: 2 cycles per packet.
- State, Send_out and DL are registered. PACKET_OUT is combinational from registers. Ack_out is combinational only under PIPE_EN.

## Configuration
- COPY_SEQ_PIPE_EN defined:
  - Ack_out = (state==EMPTY) || (final beat && Ack_in). Final beat is ORIG with DL[18]=0, or COPY.
  - A simultaneous transfer-out of the final beat and transfer-in loads the new DL and goes directly to ORIG. Send_out stays 1 with no bubble.
- Undefined: Ack_out = (state==EMPTY) && !MR, fully registered, one bubble cycle per packet.
- Both builds produce identical packet sequences for identical stimulus; only cycle timing differs.

## Structure
- Shared package ddp_pkg holds:
  - PKT_IN_W=40, PKT_OUT_W=38.
  - Field constants: DEST_MSB=28, DEST_LSB=22, LR_ORIG_BIT=21, LR_COPY_BIT=20, CPY_BIT=18.
  - State enum copy_seq_state_t {EMPTY, ORIG, COPY}.
- One sub-module, copy_pkt_fmt: purely combinational. Inputs DL and is_copy; output the 38-bit packet, including the 7-bit incrementer.

## Test plan
- Non-copy: PACKET_IN with dest=7'h05, [21]=1, [18]=0, Ack_in=1 → exactly one PACKET_OUT with dest 7'h05, LR=1, Send_out high one cycle after accept, then EMPTY.
- Copy: dest=7'h05, [21]=0, [20]=1, [18]=1 → outputs in order: (dest 7'h05, LR 0) then (dest 7'h06, LR 1); passthrough fields bit-exact in both.
- Wrap: dest=7'h7F, CPY=1 → copy packet dest=7'h00.
- Backpressure: Ack_in=0 for 5 cycles in ORIG → Send_out and PACKET_OUT held constant, Ack_out=0, new Send_in not accepted. Release → original then copy.
- Reset mid-operation: MR pulse in COPY state → Send_out=0, PACKET_OUT=0 next cycle, copy never emitted, Ack_out=1 after MR falls.
- Streaming with COPY_SEQ_PIPE_EN: 4 back-to-back non-copy packets, Send_in and Ack_in held 1 → one output per cycle, no bubble. Same stimulus without the macro → one output every 2 cycles, identical contents.
